pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Generic pipeline stage register that replaces the fixed-width IF/ID latch.
//   Adds valid/ready handshake, stall back-pressure, synchronous flush and an
//   optional 2-entry skid buffer, so in_ready is a pure register output.
//   Instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//   DATA_W     64   payload width in bits, e.g. {PC, Instruction} = 32+32
//   FLUSH_VAL  '0   DATA_W-bit payload driven on out_data after reset/flush (bubble/NOP)
//   SKID       1    1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       reset, asynchronous, active-high
//   flush      in   1       synchronous kill of all held entries (branch/jump taken)
//   in_valid   in   1       upstream payload valid
//   in_ready   out  1       stage can accept this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a live entry
//   out_ready  in   1       downstream accepts this cycle (0 = stall)
//   out_data   out  DATA_W  payload to next stage
//   occupancy  out  2       live entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//   in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   Reset (async): out_valid=0, out_data=FLUSH_VAL, skid entry invalid,
//     in_ready=1, occupancy=0. State goes to EMPTY immediately, not at the clock edge.
//   Latency: a payload accepted at edge N appears on out_data after edge N.
//   Throughput: one transfer per cycle with no bubbles while out_ready=1.
//   State machine (SKID=1). Entries are MAIN (drives out_data) and SKID.
//     EMPTY: in_fire -> ONE, MAIN<=in_data.
//     ONE:   in_fire&out_fire -> ONE, MAIN<=in_data.
//            in_fire&!out_fire -> FULL, SKID<=in_data.
//            !in_fire&out_fire -> EMPTY. Otherwise hold.
//     FULL:  in_ready=0. out_fire -> ONE, MAIN<=SKID. Otherwise hold.
//     in_ready = (state != FULL), driven from a flop.
//   SKID=0: states EMPTY/ONE only.
//     in_ready = !out_valid | out_ready (combinational).
//     in_fire&out_fire in ONE replaces MAIN.
//   Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
//     No entry is dropped, duplicated or reordered.
//   Ordering: FIFO. SKID is always older than any new input; MAIN is older than SKID.
//   Flush: at the next edge -> EMPTY, out_data<=FLUSH_VAL, occupancy=0.
//     Flush beats a simultaneous in_fire: that payload is discarded.
//     in_ready is not gated by flush.
//     The upstream producer treats a beat accepted on a flush cycle as consumed.
//     A simultaneous out_fire in the flush cycle still counts as delivered.
//   Empty stage: out_data = FLUSH_VAL, or the last consumed payload, until new
//     data arrives. Downstream qualifies out_data with out_valid only.
//   Reset asserted mid-transfer: all entries lost, outputs return to reset values
//     at once. First accept is at the first edge after rst deasserts.
//   occupancy = MAIN valid + SKID valid. Always consistent with state.
// TESTING
//   1 Reset: rst=1 mid-stream -> out_valid=0, out_data=0, in_ready=1, occupancy=0
//     immediately (async).
//   2 Streaming: in_valid=1 with data 0x1..0x8, out_ready=1 -> 0x1..0x8 out on
//     consecutive cycles, 1-cycle latency, in_ready held at 1.
//   3 Stall fill: send 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0,
//     out_data=0xA held.
//     Then out_ready=1 -> 0xA then 0xB; in_ready=1 one cycle after first out_fire.
//   4 Flush vs input: occupancy=2 with 0xA/0xB, flush=1 and in_valid=1 with 0xC
//     -> next cycle out_valid=0, occupancy=0, out_data=FLUSH_VAL.
//     0xC is never emitted.
//   5 SKID=0 build, streaming with out_ready toggling 1,0,1,0 -> in_ready tracks
//     !out_valid|out_ready combinationally; all data in order, none lost.
//   6 Random valid/ready/flush, 10k cycles, against a reference queue model ->
//     output sequence matches the model; queue cleared on flush; occupancy always
//     matches the model.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, stall back-pressure,
// synchronous flush and an optional 2-entry skid buffer. With SKID=1 the
// in_ready output comes straight from a flop, breaking the combinational
// ready path between neighbouring stages.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter bit                SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;

    logic [1:0]        w_state_d;
    logic [DATA_W-1:0] w_main_d;
    logic [DATA_W-1:0] w_skid_d;
    logic              w_in_ready_d;
    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;

    // Handshake qualifiers and outputs decoded from the state register.
    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
        w_in_ready  = SKID ? r_in_ready : (!w_out_valid || out_ready);
        w_in_fire   = in_valid && w_in_ready;
        w_out_fire  = w_out_valid && out_ready;
        unique case (r_state)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;

    // Next-state: MAIN always holds the oldest entry, SKID the newer one.
    always_comb begin
        w_state_d = r_state;
        w_main_d  = r_main;
        w_skid_d  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_d = ST_ONE;
                    w_main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_d = in_data;
                end else if (w_in_fire && SKID) begin
                    // Downstream stalled: park the newer beat behind MAIN.
                    w_state_d = ST_FULL;
                    w_skid_d  = in_data;
                end else if (w_out_fire) begin
                    // MAIN keeps the last consumed payload while empty.
                    w_state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_d = ST_ONE;
                    w_main_d  = r_skid;
                end
            end
            default: begin
                w_state_d = ST_EMPTY;
                w_main_d  = FLUSH_VAL;
            end
        endcase
        // Flush wins over any simultaneous accept; that beat is discarded.
        if (flush) begin
            w_state_d = ST_EMPTY;
            w_main_d  = FLUSH_VAL;
        end
        w_in_ready_d = (w_state_d != ST_FULL);
    end

    // State and payload registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_main     <= FLUSH_VAL;
            r_skid     <= FLUSH_VAL;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_main     <= w_main_d;
            r_skid     <= w_skid_d;
            r_in_ready <= w_in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid in both SKID=1 and SKID=0
// builds. Inputs change on the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 64;

    logic          clk;
    logic          rst;
    logic          s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [DW-1:0] s1_in_data, s1_out_data;
    logic [1:0]    s1_occ;
    logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [DW-1:0] s0_in_data, s0_out_data;
    logic [1:0]    s0_occ;

    int total;
    int bad;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (s1_flush),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_data  (s1_out_data),
        .occupancy (s1_occ)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (s0_flush),
        .in_valid  (s0_in_valid),
        .in_ready  (s0_in_ready),
        .in_data   (s0_in_data),
        .out_valid (s0_out_valid),
        .out_ready (s0_out_ready),
        .out_data  (s0_out_data),
        .occupancy (s0_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (s1_out_valid !== 1'b0 || s1_out_data !== 64'h0 || s1_in_ready !== 1'b1 ||
            s1_occ !== 2'd0) begin
            bad++;
            $display("FAIL reset_init: got v=%b d=%h r=%b occ=%0d want v=0 d=0 r=1 occ=0",
                     s1_out_valid, s1_out_data, s1_in_ready, s1_occ);
        end
        rst = 1'b0;
        // Fill both stages, then pull reset between clock edges.
        s1_in_valid = 1'b1; s1_out_ready = 1'b0; s1_in_data = 64'h55;
        s0_in_valid = 1'b1; s0_out_ready = 1'b0; s0_in_data = 64'h66;
        @(negedge clk);
        s1_in_data = 64'h77;
        s0_in_valid = 1'b0;
        @(negedge clk);
        s1_in_valid = 1'b0;
        total++;
        if (s1_occ !== 2'd2 || s0_occ !== 2'd1) begin
            bad++;
            $display("FAIL reset_prefill: got occ1=%0d occ0=%0d want 2 1", s1_occ, s0_occ);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (s1_out_valid !== 1'b0 || s1_out_data !== 64'h0 || s1_in_ready !== 1'b1 ||
            s1_occ !== 2'd0) begin
            bad++;
            $display("FAIL reset_async1: got v=%b d=%h r=%b occ=%0d want v=0 d=0 r=1 occ=0",
                     s1_out_valid, s1_out_data, s1_in_ready, s1_occ);
        end
        total++;
        if (s0_out_valid !== 1'b0 || s0_out_data !== 64'h0 || s0_occ !== 2'd0) begin
            bad++;
            $display("FAIL reset_async0: got v=%b d=%h occ=%0d want v=0 d=0 occ=0",
                     s0_out_valid, s0_out_data, s0_occ);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_streaming;
        s1_out_ready = 1'b1;
        s1_in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s1_in_data = DW'(i);
            #1;
            total++;
            if (s1_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, s1_in_ready);
            end
            @(negedge clk);
            total++;
            if (s1_out_valid !== 1'b1 || s1_out_data !== DW'(i)) begin
                bad++;
                $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h",
                         i, s1_out_valid, s1_out_data, DW'(i));
            end
        end
        s1_in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin
            bad++;
            $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0",
                     s1_out_valid, s1_occ);
        end
    endtask

    task automatic test_stall_fill;
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'hA;
        @(negedge clk);
        total++;
        if (s1_occ !== 2'd1 || s1_out_data !== 64'hA || s1_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_one: got occ=%0d d=%h r=%b want occ=1 d=a r=1",
                     s1_occ, s1_out_data, s1_in_ready);
        end
        s1_in_data = 64'hB;
        @(negedge clk);
        // Keep offering a beat that must not be taken while full.
        s1_in_data = 64'hEE;
        total++;
        if (s1_occ !== 2'd2 || s1_in_ready !== 1'b0 || s1_out_data !== 64'hA ||
            s1_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_full: got occ=%0d r=%b d=%h v=%b want occ=2 r=0 d=a v=1",
                     s1_occ, s1_in_ready, s1_out_data, s1_out_valid);
        end
        @(negedge clk);
        total++;
        if (s1_occ !== 2'd2 || s1_out_data !== 64'hA) begin
            bad++;
            $display("FAIL stall_hold: got occ=%0d d=%h want occ=2 d=a", s1_occ, s1_out_data);
        end
        s1_in_valid  = 1'b0;
        s1_out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (s1_out_data !== 64'hB || s1_occ !== 2'd1 || s1_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_second: got d=%h occ=%0d r=%b want d=b occ=1 r=1",
                     s1_out_data, s1_occ, s1_in_ready);
        end
        @(negedge clk);
        total++;
        if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin
            bad++;
            $display("FAIL stall_empty: got v=%b occ=%0d want v=0 occ=0", s1_out_valid, s1_occ);
        end
    endtask

    task automatic test_flush;
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'hA;
        @(negedge clk);
        s1_in_data = 64'hB;
        @(negedge clk);
        s1_in_data = 64'hC;
        s1_flush   = 1'b1;
        @(negedge clk);
        s1_flush    = 1'b0;
        s1_in_valid = 1'b0;
        total++;
        if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0 || s1_out_data !== 64'h0 ||
            s1_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_full: got v=%b occ=%0d d=%h r=%b want v=0 occ=0 d=0 r=1",
                     s1_out_valid, s1_occ, s1_out_data, s1_in_ready);
        end
        s1_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (s1_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_c: got v=%b d=%h want v=0", s1_out_valid, s1_out_data);
        end
        // One entry held, accept attempted during flush: the new beat is dropped.
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'hA;
        @(negedge clk);
        s1_in_data = 64'hD;
        s1_flush   = 1'b1;
        #1;
        total++;
        if (s1_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_ready: got %b want 1", s1_in_ready);
        end
        @(negedge clk);
        s1_flush    = 1'b0;
        s1_in_valid = 1'b0;
        total++;
        if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0 || s1_out_data !== 64'h0) begin
            bad++;
            $display("FAIL flush_one: got v=%b occ=%0d d=%h want v=0 occ=0 d=0",
                     s1_out_valid, s1_occ, s1_out_data);
        end
    endtask

    task automatic test_skid0;
        logic [DW-1:0] next_in;
        logic [DW-1:0] next_out;
        logic          exp_rdy;
        next_in  = 64'h11;
        next_out = 64'h11;
        s0_in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            s0_out_ready = (c < 12) ? ((c % 2) == 0) : 1'b1;
            s0_in_valid  = (c < 12);
            s0_in_data   = next_in;
            #1;
            exp_rdy = !s0_out_valid || s0_out_ready;
            total++;
            if (s0_in_ready !== exp_rdy || s0_occ > 2'd1) begin
                bad++;
                $display("FAIL skid0_ready[%0d]: got r=%b occ=%0d want r=%b occ<=1",
                         c, s0_in_ready, s0_occ, exp_rdy);
            end
            if (s0_out_valid && s0_out_ready) begin
                total++;
                if (s0_out_data !== next_out) begin
                    bad++;
                    $display("FAIL skid0_data[%0d]: got %h want %h", c, s0_out_data, next_out);
                end
                next_out++;
            end
            if (s0_in_valid && exp_rdy) next_in++;
            @(negedge clk);
        end
        total++;
        if (next_out !== 64'h17 || next_in !== 64'h17 || s0_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL skid0_count: got out=%h in=%h v=%b want out=17 in=17 v=0",
                     next_out, next_in, s0_out_valid);
        end
    endtask

    task automatic test_random;
        logic r1, v1, f1, r0, v0, f0;
        s1_flush = 1'b1; s1_in_valid = 1'b0;
        s0_flush = 1'b1; s0_in_valid = 1'b0;
        @(negedge clk);
        q1.delete();
        q0.delete();
        for (int c = 0; c < 10000; c++) begin
            if (bad > 20) break;
            s1_flush     = ($urandom_range(0, 99) < 4);
            s1_in_valid  = ($urandom_range(0, 9) < 6);
            s1_out_ready = ($urandom_range(0, 9) < 6);
            s1_in_data   = {$urandom, $urandom};
            s0_flush     = ($urandom_range(0, 99) < 4);
            s0_in_valid  = ($urandom_range(0, 9) < 6);
            s0_out_ready = ($urandom_range(0, 9) < 6);
            s0_in_data   = {$urandom, $urandom};
            #1;
            v1 = (q1.size() != 0);
            r1 = (q1.size() != 2);
            v0 = (q0.size() != 0);
            r0 = !v0 || s0_out_ready;
            total++;
            if (s1_out_valid !== v1 || s1_in_ready !== r1 || s1_occ !== 2'(q1.size())) begin
                bad++;
                $display("FAIL rand1_ctrl[%0d]: got v=%b r=%b occ=%0d want v=%b r=%b occ=%0d",
                         c, s1_out_valid, s1_in_ready, s1_occ, v1, r1, q1.size());
            end
            if (v1) begin
                total++;
                if (s1_out_data !== q1[0]) begin
                    bad++;
                    $display("FAIL rand1_data[%0d]: got %h want %h", c, s1_out_data, q1[0]);
                end
            end
            total++;
            if (s0_out_valid !== v0 || s0_in_ready !== r0 || s0_occ !== 2'(q0.size())) begin
                bad++;
                $display("FAIL rand0_ctrl[%0d]: got v=%b r=%b occ=%0d want v=%b r=%b occ=%0d",
                         c, s0_out_valid, s0_in_ready, s0_occ, v0, r0, q0.size());
            end
            if (v0) begin
                total++;
                if (s0_out_data !== q0[0]) begin
                    bad++;
                    $display("FAIL rand0_data[%0d]: got %h want %h", c, s0_out_data, q0[0]);
                end
            end
            f1 = s1_flush;
            f0 = s0_flush;
            @(posedge clk);
            if (f1) q1.delete();
            else begin
                if (v1 && s1_out_ready) void'(q1.pop_front());
                if (s1_in_valid && r1) q1.push_back(s1_in_data);
            end
            if (f0) q0.delete();
            else begin
                if (v0 && s0_out_ready) void'(q0.pop_front());
                if (s0_in_valid && r0) q0.push_back(s0_in_data);
            end
            @(negedge clk);
        end
        s1_flush = 1'b0; s1_in_valid = 1'b0;
        s0_flush = 1'b0; s0_in_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_in_data = '0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_in_data = '0;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_skid0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
